// File: rtl/branch_ctrl.sv
// Branch resolution and fetch PC generation with a counted post-redirect flush window.
// Optional performance counters are enabled by defining BRANCH_CTRL_PERF_EN.
module branch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        br_un,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        taken_o,
  output logic        misalign_o
`ifdef BRANCH_CTRL_PERF_EN
  ,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
`endif
);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        taken_q, taken_d;
  logic        mis_q, mis_d;

  logic        cond;
  logic        redirect_kind;
  logic        take;
  logic        misaligned;
  logic [31:0] base;
  logic [31:0] sum;
  logic [31:0] target;
  logic [31:0] pc_inc;

  // Unsigned compare is selected for BLTU/BGEU (funct3 11x).
  assign br_un = ex_funct3[1];

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:         cond = br_equal;
      3'b001:         cond = !br_equal;
      3'b100, 3'b110: cond = br_less;
      3'b101, 3'b111: cond = !br_less;
      default:        cond = 1'b0;
    endcase
  end

  always_comb begin
    base          = ex_jalr ? ex_rs1 : ex_pc;
    sum           = base + ex_imm;
    target        = ex_jalr ? {sum[31:1], 1'b0} : sum;
    misaligned    = target[1];
    redirect_kind = ex_jalr | ex_jal | (ex_branch & cond);
    take          = ex_valid & (state_q == StRun) & redirect_kind;
    pc_inc        = pc_q + 32'd4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    taken_d = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      StRun: begin
        if (take && !misaligned) begin
          // Redirect wins over stall.
          pc_d    = target;
          taken_d = 1'b1;
          flush_d = 1'b1;
          cnt_d   = FlushInit;
          state_d = StFlush;
        end else begin
          if (!stall) begin
            pc_d = pc_inc;
          end
          mis_d = take & misaligned;
        end
      end
      StFlush: begin
        // EX contents are wrong-path here and deliberately ignored.
        flush_d = 1'b1;
        if (!stall) begin
          pc_d  = pc_inc;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = StRun;
            flush_d = 1'b0;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o       = pc_q;
  assign flush_o    = flush_q;
  assign taken_o    = taken_q;
  assign misalign_o = mis_q;

`ifdef BRANCH_CTRL_PERF_EN
  logic        br_seen;
  logic        br_redirect;
  logic [31:0] br_cnt_q;
  logic [31:0] br_taken_cnt_q;

  // A branch only owns the redirect when no jump of higher priority is present.
  assign br_seen     = ex_valid & ex_branch & (state_q == StRun);
  assign br_redirect = br_seen & !ex_jal & !ex_jalr & cond & !misaligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q       <= 32'd0;
      br_taken_cnt_q <= 32'd0;
    end else begin
      if (br_seen) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (br_redirect) begin
        br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: driver pushes per-cycle expectations, a negedge monitor checks them.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        br_less;
  logic        br_equal;
  logic        br_un;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        taken_o;
  logic        misalign_o;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        tk;
    logic        mis;
    logic        bu;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;

  branch_ctrl #(
    .RESET_PC    (32'h0000_0100),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .ex_valid  (ex_valid),
    .ex_branch (ex_branch),
    .ex_jal    (ex_jal),
    .ex_jalr   (ex_jalr),
    .ex_funct3 (ex_funct3),
    .ex_pc     (ex_pc),
    .ex_imm    (ex_imm),
    .ex_rs1    (ex_rs1),
    .br_less   (br_less),
    .br_equal  (br_equal),
    .br_un     (br_un),
    .pc_o      (pc_o),
    .flush_o   (flush_o),
    .taken_o   (taken_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp = n_cmp + 5;
      if (pc_o !== e.pc) begin
        n_bad++;
        $display("FAIL step%0d pc_o: got %h want %h", e.id, pc_o, e.pc);
      end
      if (flush_o !== e.fl) begin
        n_bad++;
        $display("FAIL step%0d flush_o: got %b want %b", e.id, flush_o, e.fl);
      end
      if (taken_o !== e.tk) begin
        n_bad++;
        $display("FAIL step%0d taken_o: got %b want %b", e.id, taken_o, e.tk);
      end
      if (misalign_o !== e.mis) begin
        n_bad++;
        $display("FAIL step%0d misalign_o: got %b want %b", e.id, misalign_o, e.mis);
      end
      if (br_un !== e.bu) begin
        n_bad++;
        $display("FAIL step%0d br_un: got %b want %b", e.id, br_un, e.bu);
      end
    end
  end

  task automatic idle_ex();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
    ex_jal    = 1'b0;
    ex_jalr   = 1'b0;
    ex_funct3 = 3'b000;
    ex_pc     = 32'h0;
    ex_imm    = 32'h0;
    ex_rs1    = 32'h0;
    br_less   = 1'b0;
    br_equal  = 1'b0;
  endtask

  // Advance to just after the next rising edge and return EX inputs to idle.
  task automatic nxt();
    @(posedge clk);
    #1;
    idle_ex();
  endtask

  // Expected outputs during the current cycle (state from the last edge, br_un from current inputs).
  task automatic expect_now(input logic [31:0] pc, input logic fl, input logic tk,
                            input logic mis, input logic bu);
    exp_t e;
    e.pc  = pc;
    e.fl  = fl;
    e.tk  = tk;
    e.mis = mis;
    e.bu  = bu;
    e.id  = step_id;
    step_id++;
    q.push_back(e);
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic lt, input logic eq);
    ex_valid  = 1'b1;
    ex_branch = 1'b1;
    ex_funct3 = f3;
    ex_pc     = pc;
    ex_imm    = imm;
    br_less   = lt;
    br_equal  = eq;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    idle_ex();

    // Reset held for two edges, then release.
    nxt(); rst_n = 1'b0; expect_now(32'h100, 0, 0, 0, 0);
    nxt(); rst_n = 1'b1; expect_now(32'h100, 0, 0, 0, 0);
    nxt();               expect_now(32'h104, 0, 0, 0, 0);
    // BEQ taken 0x200+0x40.
    nxt(); set_br(3'b000, 32'h200, 32'h40, 0, 1); expect_now(32'h108, 0, 0, 0, 0);
    nxt();               expect_now(32'h240, 1, 1, 0, 0);
    nxt();               expect_now(32'h244, 1, 0, 0, 0);
    // BLTU not taken, then BGEU taken 0x300-8.
    nxt(); set_br(3'b110, 32'h250, 32'h40, 0, 0); expect_now(32'h248, 0, 0, 0, 1);
    nxt(); set_br(3'b111, 32'h300, 32'hFFFF_FFF8, 0, 0); expect_now(32'h24C, 0, 0, 0, 1);
    nxt();               expect_now(32'h2F8, 1, 1, 0, 0);
    nxt();               expect_now(32'h2FC, 1, 0, 0, 0);
    // JALR with bit0 masked: 0x1001+4 -> 0x1004.
    nxt(); ex_valid = 1; ex_jalr = 1; ex_rs1 = 32'h1001; ex_imm = 32'h4;
    expect_now(32'h300, 0, 0, 0, 0);
    nxt();               expect_now(32'h1004, 1, 1, 0, 0);
    nxt();               expect_now(32'h1008, 1, 0, 0, 0);
    // JALR to 0x1002: misaligned, no redirect.
    nxt(); ex_valid = 1; ex_jalr = 1; ex_rs1 = 32'h1002; ex_imm = 32'h0;
    expect_now(32'h100C, 0, 0, 0, 0);
    nxt();               expect_now(32'h1010, 0, 0, 1, 0);
    // BNE taken while stalled: redirect still happens.
    nxt(); stall = 1; set_br(3'b001, 32'h400, 32'h10, 0, 0); expect_now(32'h1014, 0, 0, 0, 0);
    // Three stalled FLUSH cycles; a taken branch during FLUSH is ignored.
    nxt(); stall = 1;    expect_now(32'h410, 1, 1, 0, 0);
    nxt(); stall = 1;    expect_now(32'h410, 1, 0, 0, 0);
    nxt(); stall = 1; set_br(3'b000, 32'h500, 32'h8, 0, 1); expect_now(32'h410, 1, 0, 0, 0);
    nxt(); stall = 0; set_br(3'b000, 32'h500, 32'h8, 0, 1); expect_now(32'h410, 1, 0, 0, 0);
    nxt();               expect_now(32'h414, 1, 0, 0, 0);
    // JAL target wraps: 0xFFFF_FFF0+0x20.
    nxt(); ex_valid = 1; ex_jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
    expect_now(32'h418, 0, 0, 0, 0);
    // Reset in the first FLUSH cycle.
    nxt(); rst_n = 0;    expect_now(32'h10, 1, 1, 0, 0);
    nxt(); rst_n = 1;    expect_now(32'h100, 0, 0, 0, 0);
    // Stall in RUN holds; funct3 010 never taken.
    nxt(); stall = 1;    expect_now(32'h104, 0, 0, 0, 0);
    nxt(); stall = 0; set_br(3'b010, 32'h600, 32'h8, 1, 1); expect_now(32'h104, 0, 0, 0, 1);
    // Jump to 0xFFFF_FFFC, then PC+4 wraps to 0.
    nxt(); ex_valid = 1; ex_jal = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
    expect_now(32'h108, 0, 0, 0, 0);
    nxt();               expect_now(32'hFFFF_FFFC, 1, 1, 0, 0);
    nxt();               expect_now(32'h0, 1, 0, 0, 0);
    // All three kinds set: JALR wins (0x2000+0x10), not branch or JAL.
    nxt(); ex_valid = 1; ex_jalr = 1; ex_jal = 1; ex_branch = 1; ex_funct3 = 3'b000;
    br_equal = 0; ex_rs1 = 32'h2000; ex_imm = 32'h10; ex_pc = 32'h3000;
    expect_now(32'h4, 0, 0, 0, 0);
    nxt();               expect_now(32'h2010, 1, 1, 0, 0);
    nxt();               expect_now(32'h2014, 1, 0, 0, 0);
    // JAL without ex_valid is not taken.
    nxt(); ex_jal = 1; ex_pc = 32'h7000; ex_imm = 32'h100; expect_now(32'h2018, 0, 0, 0, 0);
    // BLT taken / BGE not taken.
    nxt(); set_br(3'b100, 32'h800, 32'h20, 1, 0); expect_now(32'h201C, 0, 0, 0, 0);
    nxt();               expect_now(32'h820, 1, 1, 0, 0);
    nxt();               expect_now(32'h824, 1, 0, 0, 0);
    nxt(); set_br(3'b101, 32'h900, 32'h20, 1, 0); expect_now(32'h828, 0, 0, 0, 0);
    nxt();               expect_now(32'h82C, 0, 0, 0, 0);

    begin
      int guard;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (q.size() > 0) begin
        n_bad++;
        $display("FAIL drain: got %0d pending want 0", q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
